// File: rtl/lunxun_pkg.sv
// Shared constants and types for the 30-channel downlink/uplink data path.
package lunxun_pkg;

  // Frame tag carried in header bits [63:32]
  localparam logic [31:0] HEAD = 32'hadf90c00;

  // 64-bit words per frame, header included
  localparam int FRAME_WORDS = 128;

  // Channels are numbered 1..NCH
  localparam int NCH = 30;

  // Width of a latched channel number
  localparam int CH_W = 7;

  // Payload counter width and the payload length it has to reach
  localparam int CNT_W = 7;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } state_t;

  // True when a raw header channel field addresses a real channel
  function automatic logic ch_in_range(input logic [7:0] ch);
    return (ch >= 8'd1) && (ch <= 8'(NCH));
  endfunction

endpackage

// File: rtl/unpack_64to32.sv
// Splits each accepted 64-bit payload word into two 32-bit FIFO writes,
// low half first, high half on the following cycle.
module unpack_64to32
  import lunxun_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic [63:0]    word,
  input  logic [NCH:1]   sel,
  output logic           pend_hi,
  output logic [NCH:1]   wrreq,
  output logic [31:0]    data
);

  logic [31:0] hold;

  // Issue the low half on load, then the parked high half one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_hi <= 1'b0;
      wrreq   <= '0;
      data    <= '0;
      hold    <= '0;
    end else if (load) begin
      wrreq   <= sel;
      data    <= word[31:0];
      hold    <= word[63:32];
      pend_hi <= 1'b1;
    end else if (pend_hi) begin
      wrreq   <= sel;
      data    <= hold;
      pend_hi <= 1'b0;
    end else begin
      wrreq   <= '0;
    end
  end

endmodule

// File: rtl/frame_dispatch30.sv
// Downlink frame dispatcher: hunts for tagged headers, routes each payload
// to the addressed channel FIFO as 32-bit writes, drops bad or full frames.
module frame_dispatch30
  import lunxun_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [63:0]        in_data,
  output logic               in_ready,
  input  logic [NCH:1]       chan_full,
  output logic [NCH:1]       wrreq,
  output logic [32*NCH-1:0]  data_out,
  output logic               frm_err,
  output logic [15:0]        drop_cnt
);

  state_t          state;
  logic [CH_W-1:0] ch_q;
  logic [CNT_W-1:0] cnt;
  logic            pend_hi;
  logic            accept;
  logic            load;
  logic [7:0]      hdr_ch;
  logic            tag_ok;
  logic            ch_ok;
  logic            ch_full;
  logic [31:0]     full_ext;
  logic [NCH:1]    sel;
  logic [31:0]     word_out;

  assign accept   = in_valid && in_ready;
  assign load     = accept && (state == PASS);
  assign hdr_ch   = in_data[7:0];
  assign tag_ok   = (in_data[63:32] == HEAD);
  assign ch_ok    = ch_in_range(hdr_ch);
  // Pad so every 5-bit channel index lands inside the vector
  assign full_ext = {1'b0, chan_full, 1'b0};
  assign ch_full  = ch_ok && full_ext[hdr_ch[4:0]];
  assign data_out = {NCH{word_out}};

  // Ready depends only on state; PASS throttles to one word per two cycles
  always_comb begin
    in_ready = 1'b1;
    case (state)
      PASS:    in_ready = !pend_hi && (cnt != LAST_CNT);
      default: in_ready = 1'b1;
    endcase
  end

  // One-hot write select for the latched channel
  always_comb begin
    sel = '0;
    for (int i = 1; i <= NCH; i++) begin
      sel[i] = (ch_q == CH_W'(i));
    end
  end

  // Header decode, payload counting and drop bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HUNT;
      ch_q     <= '0;
      cnt      <= '0;
      frm_err  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      frm_err <= 1'b0;
      case (state)
        HUNT: begin
          if (accept) begin
            if (!tag_ok) begin
              frm_err <= 1'b1;
            end else if (!ch_ok) begin
              frm_err <= 1'b1;
              if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
              cnt   <= '0;
              state <= DROP;
            end else if (ch_full) begin
              if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
              cnt   <= '0;
              state <= DROP;
            end else begin
              ch_q  <= hdr_ch[CH_W-1:0];
              cnt   <= '0;
              state <= PASS;
            end
          end
        end
        PASS: begin
          if (load) begin
            cnt <= cnt + CNT_W'(1);
          end else if (pend_hi && (cnt == LAST_CNT)) begin
            state <= HUNT;
          end
        end
        DROP: begin
          if (accept) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_CNT - CNT_W'(1)) state <= HUNT;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

  unpack_64to32 u_unpack (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .word    (in_data),
    .sel     (sel),
    .pend_hi (pend_hi),
    .wrreq   (wrreq),
    .data    (word_out)
  );

endmodule

// File: tb/tb_frame_dispatch30.sv
// Directed bench for frame_dispatch30.
module tb_frame_dispatch30;
  import lunxun_pkg::*;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic [63:0]        in_data;
  logic               in_ready;
  logic [NCH:1]       chan_full;
  logic [NCH:1]       wrreq;
  logic [32*NCH-1:0]  data_out;
  logic               frm_err;
  logic [15:0]        drop_cnt;

  int total;
  int bad;
  int total_writes;
  int base;
  int data_bad;
  int onehot_bad;
  int err_pulses;
  int wr_cnt [0:31];
  int hdr_wait;
  int w_before;
  int c_before;

  frame_dispatch30 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .chan_full (chan_full),
    .wrreq     (wrreq),
    .data_out  (data_out),
    .frm_err   (frm_err),
    .drop_cnt  (drop_cnt)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe writes and error pulses mid-cycle; expected data is the
  // running write index since the frame base the main sequence sets
  initial begin
    total_writes = 0;
    data_bad     = 0;
    onehot_bad   = 0;
    err_pulses   = 0;
    for (int i = 0; i < 32; i++) wr_cnt[i] = 0;
  end

  always @(negedge clk) begin
    if (frm_err) err_pulses++;
    if (wrreq != '0) begin
      if (!$onehot(wrreq)) onehot_bad++;
      if (data_out !== {NCH{data_out[31:0]}}) data_bad++;
      if (data_out[31:0] !== 32'(total_writes - base)) data_bad++;
      total_writes++;
      for (int i = 1; i <= NCH; i++) if (wrreq[i]) wr_cnt[i]++;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one word and hold it until accepted; reports cycles waited
  task automatic applyStimulus(input logic [63:0] w, output int waited);
    in_valid = 1'b1;
    in_data  = w;
    waited   = 0;
    while (!in_ready && waited < 16) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("accept_timeout", 64'(waited < 16), 64'd1);
    @(posedge clk); #1;
  endtask

  // Header plus 127 payload words {2k+1+off, 2k+off}
  task automatic sendFrame(input int ch, input int off, input bit pass,
                           input int full_at, input int stop_after, output int hw);
    int n;
    applyStimulus({HEAD, 32'(ch)}, hw);
    for (int k = 0; k < FRAME_WORDS - 1; k++) begin
      if (k == full_at) chan_full[ch] = 1'b1;
      applyStimulus({32'(2*k + 1 + off), 32'(2*k + off)}, n);
      checkOutput("ready_gap", 64'(n), (pass && k > 0) ? 64'd1 : 64'd0);
      if (k == stop_after) break;
    end
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    base      = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    chan_full = '0;
    #1;
    checkOutput("rst_wrreq", 64'(wrreq), 64'd0);
    checkOutput("rst_data", 64'(data_out === '0), 64'd1);
    checkOutput("rst_err", 64'(frm_err), 64'd0);
    checkOutput("rst_drop", 64'(drop_cnt), 64'd0);
    checkOutput("rst_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    $display("[TB] channel 5 frame");
    base = total_writes;
    sendFrame(5, 0, 1'b1, -1, -1, hdr_wait);
    idle(4);
    checkOutput("ch5_writes", 64'(wr_cnt[5]), 64'd254);
    checkOutput("ch5_total", 64'(total_writes), 64'd254);
    checkOutput("ch5_data", 64'(data_bad), 64'd0);
    checkOutput("ch5_onehot", 64'(onehot_bad), 64'd0);
    checkOutput("ch5_err", 64'(err_pulses), 64'd0);

    $display("[TB] bad tag then channel 1");
    w_before = total_writes;
    applyStimulus(64'h12345678_00000003, hdr_wait);
    base = total_writes;
    sendFrame(1, 0, 1'b1, -1, -1, hdr_wait);
    idle(4);
    checkOutput("badtag_err", 64'(err_pulses), 64'd1);
    checkOutput("badtag_ch3", 64'(wr_cnt[3]), 64'd0);
    checkOutput("ch1_writes", 64'(wr_cnt[1]), 64'd254);
    checkOutput("ch1_total", 64'(total_writes - w_before), 64'd254);
    checkOutput("badtag_drop", 64'(drop_cnt), 64'd0);
    checkOutput("ch1_data", 64'(data_bad), 64'd0);

    $display("[TB] bad channel 31 then channel 2");
    w_before = total_writes;
    sendFrame(31, 0, 1'b0, -1, -1, hdr_wait);
    idle(3);
    checkOutput("badch_err", 64'(err_pulses), 64'd2);
    checkOutput("badch_drop", 64'(drop_cnt), 64'd1);
    checkOutput("badch_nowrite", 64'(total_writes - w_before), 64'd0);
    base = total_writes;
    sendFrame(2, 0, 1'b1, -1, -1, hdr_wait);
    idle(4);
    checkOutput("ch2_writes", 64'(wr_cnt[2]), 64'd254);
    checkOutput("ch2_data", 64'(data_bad), 64'd0);

    $display("[TB] full channel 30");
    chan_full[30] = 1'b1;
    w_before = total_writes;
    sendFrame(30, 0, 1'b0, -1, -1, hdr_wait);
    idle(3);
    chan_full[30] = 1'b0;
    checkOutput("full_drop", 64'(drop_cnt), 64'd2);
    checkOutput("full_noerr", 64'(err_pulses), 64'd2);
    checkOutput("full_nowrite", 64'(total_writes - w_before), 64'd0);
    checkOutput("full_ch30", 64'(wr_cnt[30]), 64'd0);

    $display("[TB] full rises mid channel 2 frame");
    c_before = wr_cnt[2];
    base = total_writes;
    sendFrame(2, 0, 1'b1, 10, -1, hdr_wait);
    idle(4);
    chan_full[2] = 1'b0;
    checkOutput("midfull_writes", 64'(wr_cnt[2] - c_before), 64'd254);
    checkOutput("midfull_drop", 64'(drop_cnt), 64'd2);
    checkOutput("midfull_data", 64'(data_bad), 64'd0);

    $display("[TB] back-to-back channel 30 then channel 1");
    c_before = wr_cnt[1];
    w_before = total_writes;
    base = total_writes;
    sendFrame(30, 0, 1'b1, -1, -1, hdr_wait);
    sendFrame(1, 254, 1'b1, -1, -1, hdr_wait);
    checkOutput("b2b_hdr_wait", 64'(hdr_wait), 64'd1);
    idle(4);
    checkOutput("b2b_ch30", 64'(wr_cnt[30]), 64'd254);
    checkOutput("b2b_ch1", 64'(wr_cnt[1] - c_before), 64'd254);
    checkOutput("b2b_total", 64'(total_writes - w_before), 64'd508);
    checkOutput("b2b_data", 64'(data_bad), 64'd0);
    checkOutput("b2b_onehot", 64'(onehot_bad), 64'd0);
    checkOutput("b2b_err", 64'(err_pulses), 64'd2);

    $display("[TB] reset mid channel 7 frame");
    base = total_writes;
    sendFrame(7, 0, 1'b1, -1, 59, hdr_wait);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_wrreq", 64'(wrreq), 64'd0);
    checkOutput("midrst_data", 64'(data_out === '0), 64'd1);
    checkOutput("midrst_ready", 64'(in_ready), 64'd1);
    checkOutput("midrst_drop", 64'(drop_cnt), 64'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);
    checkOutput("midrst_ch7", 64'(wr_cnt[7]), 64'd118);
    base = total_writes;
    sendFrame(9, 0, 1'b1, -1, -1, hdr_wait);
    idle(4);
    checkOutput("postrst_ch9", 64'(wr_cnt[9]), 64'd254);
    checkOutput("postrst_data", 64'(data_bad), 64'd0);
    checkOutput("postrst_err", 64'(err_pulses), 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
